hc_sum_n: RTL and testbench
===========================

# hc_sum_n

Reduces the elementwise h·C product tensor over the state dimension N: y[b,h,p] = Σₙ hC[b,h,p,n]. It consumes the packed output of the h·C multiply stage and produces the per-(b,h,p) SSM output contribution. It uses the same start/done, hold-inputs-stable protocol and the same pipelined FP16 arithmetic wrappers as the rest of the Mamba-2 datapath. Work is lane-parallel over rows (b,h,p); accumulation across n is serialized in passes so that adder latency never creates a read-after-write hazard.

## Interface
- B, 1, batch size
- H, 4, heads
- P, 4, head dim
- N, 4, state dim (≥1)
- DW, 16, element width (FP16)
- A_LAT, 6, fp16 adder pipeline latency in cycles
- PAR, 16, parallel adder lanes (≥1)
- Derived: R = B·H·P rows; Q = ceil(R/PAR) issue cycles per pass.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, active-low; asserting it resets the block immediately (asynchronous); release is synchronous to clk
- start  in  1  request; sampled only in IDLE
- hC_flat  in  R·N·DW  element (r,n) at word index r·N+n, with r = b·H·P + h·P + p; caller holds it stable from start until done
- y_flat  out  R·DW  word r = y[r]; reset value 0
- done  out  1  one-cycle pulse; reset value 0

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE
  - done ← 0.
  - On start: n ← 1, lane group q ← 0, go to LOAD.
  - start outside IDLE is ignored; no queuing.
- LOAD (1 cycle)
  - acc[r] ← hC[r,0] for all r. No add is issued for column 0.
  - Go to DONE if N = 1, else to ISSUE.
- ISSUE (Q cycles per pass)
  - Lane i, group q, row r = q·PAR + i.
  - If r < R: present a = acc[r], b = hC[r,n], and assert that lane's valid_in, carrying tag r.
  - If r ≥ R: lane valid_in = 0.
  - After group Q−1, go to WAIT with wait counter 0.
- Write-back (any state)
  - When a lane's valid_out is high: acc[tag] ← result.
  - Tags travel in a shift register of depth A_LAT, aligned to the adder.
- WAIT
  - Counts A_LAT cycles, so every result of the pass is written back before the next pass reads acc.
  - Then, if n = N−1: go to DONE.
  - Else: n ← n+1, q ← 0, go to ISSUE.
- DONE (1 cycle)
  - y_flat ← acc; done ← 1; go to IDLE.
  - y_flat holds until the next DONE or reset.
- Arithmetic
  - IEEE FP16. Rounding, denormals and specials are as produced by fp16_add_wrapper.
  - Summation order is fixed: ((x0+x1)+x2)+…, which makes results bit-reproducible.
- Reset mid-operation
  - State → IDLE; acc, y_flat, tags, counters → 0; done → 0.
  - Lane valid_in is forced 0, and in-flight adder results are discarded (write-back is gated by state ≠ IDLE).

## Timing
- Edge e0 samples start in IDLE.
- done is high during exactly one cycle, after edge e_T, where T = 2 + (N−1)·(Q + A_LAT).
- y_flat is valid in that same cycle.
- Defaults: Q = 1, T = 2 + 3·7 = 23.
- Back-to-back runs: start may be asserted in the cycle done is high. It is sampled at the following edge, because the block is then in IDLE.
- The minimum gap between done pulses is T+1 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package (mamba2_pkg) holds:
  - FP16 constants: FP16_ZERO = 16'h0000, FP16_ONE = 16'h3C00.
  - State encoding and the ceil-div helper used for Q.
  - The row-index function r = b·H·P + h·P + p, also used by hC and the y-assembly stage.
- One sub-module: fp16_add_wrapper, instantiated PAR times.
  - Ports: clk, a, b, valid_in, result, valid_out.
  - Fixed latency A_LAT.
- The tag shift register and the acc array live in this block.

## Test plan
- All hC = 1.0 (0x3C00), default parameters, start pulse:
  - done exactly 23 cycles after the sampling edge.
  - Every y = 4.0 (0x4400).
  - done high for 1 cycle only.
- Row r = [1.0, −1.0, 2.0, −2.0] for even r; [0.5, 0.5, 0.5, 0.5] for odd r:
  - Even y = 0x0000, odd y = 2.0 (0x4000).
  - Checks lane/tag routing.
- PAR = 3, R = 16 (Q = 6), hC[r,n] = r+n as FP16:
  - Sum over n of (r+n) gives y[r] = 4r+6.
  - T = 2 + 3·12 = 38.
  - Lane 2 of group 5 (r = 17) never asserts valid_in.
- N = 1:
  - y = hC[r,0] bit-exact; T = 2; the adder valid_in is never asserted.
- Reset and restart:
  - Pull rst_n low at cycle 10 of a run: y_flat = 0 and done = 0 immediately.
  - Release rst_n, then start again: a correct result in T cycles, with no stale write-back.
- Start while busy:
  - start pulses at cycles 5 and 12 of a run are ignored: a single done pulse at T.
  - start in the done cycle launches a second run whose done is at T+1 after the first.

Source files
------------

// File: rtl/mamba2_pkg.sv
// Shared Mamba-2 datapath definitions: FP16 constants, FSM encoding and
// index helpers used by the reduction blocks and their callers.
package mamba2_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

    function automatic int row_idx(input int b, input int h, input int p,
                                   input int heads, input int hdim);
        return b * heads * hdim + h * hdim + p;
    endfunction

endpackage

// File: rtl/hc_sum_n_if.sv
// Start/done request bus for hc_sum_n: packed hC operand in, packed y out.
interface hc_sum_n_if #(
    parameter int R  = 16,
    parameter int N  = 4,
    parameter int DW = 16
);
    logic                start;
    logic [R*N*DW-1:0]   hC_flat;
    logic [R*DW-1:0]     y_flat;
    logic                done;

    modport master (output start, output hC_flat, input  y_flat, input  done);
    modport slave  (input  start, input  hC_flat, output y_flat, output done);
endinterface

// File: rtl/fp16_add_wrapper.sv
// IEEE FP16 adder (round-to-nearest-even, gradual underflow) behind a fixed
// A_LAT-deep register pipeline; one result per cycle.
module fp16_add_wrapper
    import mamba2_pkg::*;
#(
    parameter int A_LAT = 6
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        valid_in,
    output logic [15:0] result,
    output logic        valid_out
);

    function automatic logic [15:0] fp16_add(input logic [15:0] fa, input logic [15:0] fb);
        logic [15:0] x, y;
        logic        a_nan, b_nan, a_inf, b_inf, s, up;
        logic [5:0]  ex, ey, e, d;
        logic [13:0] big, sm, aligned, m;
        logic [27:0] tmp;
        logic [14:0] sum;
        logic [11:0] mr;
        logic [10:0] mant;
        a_nan = (fa[14:10] == 5'h1F) && (fa[9:0] != 10'h0);
        b_nan = (fb[14:10] == 5'h1F) && (fb[9:0] != 10'h0);
        a_inf = (fa[14:10] == 5'h1F) && (fa[9:0] == 10'h0);
        b_inf = (fb[14:10] == 5'h1F) && (fb[9:0] == 10'h0);
        if (a_nan || b_nan || (a_inf && b_inf && (fa[15] != fb[15]))) return 16'h7E00;
        if (a_inf) return fa;
        if (b_inf) return fb;
        if (fa[14:0] >= fb[14:0]) begin x = fa; y = fb; end
        else                      begin x = fb; y = fa; end
        ex  = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
        ey  = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
        big = {x[14:10] != 5'd0, x[9:0], 3'b000};
        sm  = {y[14:10] != 5'd0, y[9:0], 3'b000};
        d   = ex - ey;
        // Bits shifted past the guard/round positions fold into the sticky bit.
        tmp     = {sm, 14'b0} >> ((d > 6'd15) ? 6'd15 : d);
        aligned = tmp[27:14] | {13'b0, |tmp[13:0]};
        s = x[15];
        e = ex;
        if (x[15] == y[15]) begin
            sum = {1'b0, big} + {1'b0, aligned};
            if (sum[14]) begin
                m = sum[14:1] | {13'b0, sum[0]};
                e = ex + 6'd1;
            end else begin
                m = sum[13:0];
            end
        end else begin
            m = big - aligned;
            if (m == 14'd0) return FP16_ZERO;
            for (int i = 0; i < 13; i++) begin
                if (!m[13] && (e > 6'd1)) begin
                    m = m << 1;
                    e = e - 6'd1;
                end
            end
        end
        up = m[2] & (m[3] | m[1] | m[0]);
        mr = {1'b0, m[13:3]} + {11'b0, up};
        if (mr[11]) begin
            mant = mr[11:1];
            e    = e + 6'd1;
        end else begin
            mant = mr[10:0];
        end
        if (e >= 6'd31) return {s, 5'h1F, 10'h0};
        return {s, mant[10] ? e[4:0] : 5'd0, mant[9:0]};
    endfunction

    logic [15:0] r_res [A_LAT];
    logic        r_vld [A_LAT];

    // The pipe has no reset port; the owner discards anything emerging while idle.
    always_ff @(posedge clk) begin
        r_res[0] <= fp16_add(a, b);
        r_vld[0] <= valid_in;
        for (int k = 1; k < A_LAT; k++) begin
            r_res[k] <= r_res[k-1];
            r_vld[k] <= r_vld[k-1];
        end
    end

    assign result    = r_res[A_LAT-1];
    assign valid_out = r_vld[A_LAT-1];

endmodule

// File: rtl/hc_sum_n.sv
// Reduces hC[r,n] over n into y[r] with PAR FP16 adder lanes; each pass adds one
// column and fully drains before the next, so acc never sees a RAW hazard.
module hc_sum_n
    import mamba2_pkg::*;
#(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int A_LAT = 6,
    parameter int PAR   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    hc_sum_n_if.slave  bus
);

    localparam int R     = B * H * P;
    localparam int Q     = ceil_div(R, PAR);
    localparam int TAG_W = clog2_min1(R);
    localparam int Q_W   = clog2_min1(Q);
    localparam int N_W   = clog2_min1(N);
    localparam int W_W   = clog2_min1(A_LAT);

    state_t            r_state;
    logic [Q_W-1:0]    r_q;
    logic [N_W-1:0]    r_n;
    logic [W_W-1:0]    r_wcnt;
    logic              r_done;
    logic [R*DW-1:0]   r_y;
    logic [DW-1:0]     r_acc [R];
    logic [TAG_W-1:0]  r_tag [PAR][A_LAT];

    logic [PAR-1:0]    w_lane_vld;
    logic [DW-1:0]     w_lane_a   [PAR];
    logic [DW-1:0]     w_lane_b   [PAR];
    logic [TAG_W-1:0]  w_lane_tag [PAR];
    logic [DW-1:0]     w_res      [PAR];
    logic [PAR-1:0]    w_vld_out;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        int row;
        row        = 0;
        w_lane_vld = '0;
        for (int i = 0; i < PAR; i++) begin
            w_lane_a[i]   = FP16_ZERO;
            w_lane_b[i]   = FP16_ZERO;
            w_lane_tag[i] = '0;
            row           = int'(r_q) * PAR + i;
            if ((r_state == ST_ISSUE) && (row < R)) begin
                w_lane_vld[i] = 1'b1;
                w_lane_a[i]   = r_acc[TAG_W'(row)];
                w_lane_b[i]   = bus.hC_flat[(row * N + int'(r_n)) * DW +: DW];
                w_lane_tag[i] = TAG_W'(row);
            end
        end
    end

    for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
        fp16_add_wrapper #(.A_LAT(A_LAT)) u_add (
            .clk       (clk),
            .a         (w_lane_a[gi]),
            .b         (w_lane_b[gi]),
            .valid_in  (w_lane_vld[gi]),
            .result    (w_res[gi]),
            .valid_out (w_vld_out[gi])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAR; i++)
                for (int k = 0; k < A_LAT; k++)
                    r_tag[i][k] <= '0;
        end else begin
            for (int i = 0; i < PAR; i++) begin
                r_tag[i][0] <= w_lane_tag[i];
                for (int k = 1; k < A_LAT; k++)
                    r_tag[i][k] <= r_tag[i][k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_n     <= '0;
            r_wcnt  <= '0;
            r_done  <= 1'b0;
            r_y     <= '0;
            // NOTE: acc is a small register array, not RAM, so clearing it on reset is cheap and required.
            for (int r = 0; r < R; r++)
                r_acc[r] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_n     <= N_W'(1);
                        r_q     <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int r = 0; r < R; r++)
                        r_acc[r] <= bus.hC_flat[r * N * DW +: DW];
                    r_state <= (N == 1) ? ST_DONE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (r_q == Q_W'(Q - 1)) begin
                        r_wcnt  <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_q <= r_q + Q_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == W_W'(A_LAT - 1)) begin
                        if (r_n == N_W'(N - 1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_n     <= r_n + N_W'(1);
                            r_q     <= '0;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + W_W'(1);
                    end
                end
                ST_DONE: begin
                    for (int r = 0; r < R; r++)
                        r_y[r * DW +: DW] <= r_acc[r];
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Results still draining out of the adders after a reset are dropped while idle.
            for (int i = 0; i < PAR; i++)
                if (w_vld_out[i] && (r_state != ST_IDLE))
                    r_acc[r_tag[i][A_LAT-1]] <= w_res[i];
        end
    end

    assign bus.y_flat = r_y;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_hc_sum_n.sv
// Directed bench for hc_sum_n: default, PAR=3 and N=1 instances sharing clk/rst_n.
module tb_hc_sum_n;
    import mamba2_pkg::*;

    localparam int R  = 16;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hc_sum_n_if #(.R(R), .N(N), .DW(DW)) bus0 ();
    hc_sum_n_if #(.R(R), .N(N), .DW(DW)) bus1 ();
    hc_sum_n_if #(.R(R), .N(1), .DW(DW)) bus2 ();

    hc_sum_n #(.B(1), .H(4), .P(4), .N(4), .DW(16), .A_LAT(6), .PAR(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    hc_sum_n #(.B(1), .H(4), .P(4), .N(4), .DW(16), .A_LAT(6), .PAR(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    hc_sum_n #(.B(1), .H(4), .P(4), .N(1), .DW(16), .A_LAT(6), .PAR(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int total = 0;
    int bad   = 0;

    int vld_all1  = 0;
    int vld_lane2 = 0;
    int vld_all2  = 0;
    always @(negedge clk) begin
        vld_all1  <= vld_all1 + $countones(dut1.w_lane_vld);
        vld_lane2 <= vld_lane2 + int'(dut1.w_lane_vld[2]);
        vld_all2  <= vld_all2 + $countones(dut2.w_lane_vld);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] int_to_fp16(input int v);
        int e;
        if (v == 0) return 16'h0000;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 5'(e + 15), 10'((v << (10 - e)) & 'h3FF)};
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            0:       return bus0.done;
            1:       return bus1.done;
            default: return bus2.done;
        endcase
    endfunction

    function automatic logic [15:0] y_word(input int which, input int r);
        case (which)
            0:       return bus0.y_flat[r*16 +: 16];
            1:       return bus1.y_flat[r*16 +: 16];
            default: return bus2.y_flat[r*16 +: 16];
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       bus0.start = v;
            1:       bus1.start = v;
            default: bus2.start = v;
        endcase
    endtask

    task automatic set_hc(input int which, input int r, input int n, input logic [15:0] v);
        case (which)
            0:       bus0.hC_flat[(r*N + n)*16 +: 16] = v;
            1:       bus1.hC_flat[(r*N + n)*16 +: 16] = v;
            default: bus2.hC_flat[r*16 +: 16] = v;
        endcase
    endtask

    // Pulses start, returns the edge count from the sampling edge to the first done cycle.
    task automatic run(input int which, output int lat);
        lat = -1;
        @(negedge clk); set_start(which, 1'b1);
        @(posedge clk);
        @(negedge clk); set_start(which, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_done(which)) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, a1, l2, a2, d1, d2, nd;
        logic [15:0] v;

        rst_n = 1'b0;
        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
        bus0.hC_flat = '0; bus1.hC_flat = '0; bus2.hC_flat = '0;
        repeat (3) @(negedge clk);
        check("reset_done0", 64'(bus0.done), 64'd0);
        check("reset_y0", 64'(|bus0.y_flat), 64'd0);
        check("reset_done2", 64'(bus2.done), 64'd0);
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All ones: every row sums to 4.0.
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++) set_hc(0, r, n, FP16_ONE);
        run(0, lat);
        check("ones_lat", 64'(lat), 64'd23);
        for (int r = 0; r < R; r++) check($sformatf("ones_y%0d", r), 64'(y_word(0, r)), 64'h4400);
        @(negedge clk);
        check("ones_done_width", 64'(bus0.done), 64'd0);

        // Even rows cancel to +0, odd rows sum four halves to 2.0.
        for (int h = 0; h < 4; h++)
            for (int p = 0; p < 4; p++) begin
                int r;
                r = row_idx(0, h, p, 4, 4);
                if (r % 2 == 0) begin
                    set_hc(0, r, 0, 16'h3C00); set_hc(0, r, 1, 16'hBC00);
                    set_hc(0, r, 2, 16'h4000); set_hc(0, r, 3, 16'hC000);
                end else begin
                    for (int n = 0; n < N; n++) set_hc(0, r, n, 16'h3800);
                end
            end
        run(0, lat);
        check("alt_lat", 64'(lat), 64'd23);
        for (int r = 0; r < R; r++)
            check($sformatf("alt_y%0d", r), 64'(y_word(0, r)), (r % 2 == 0) ? 64'h0000 : 64'h4000);

        // PAR=3: six lane groups, last group has one idle lane.
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++) set_hc(1, r, n, int_to_fp16(r + n));
        a1 = vld_all1; l2 = vld_lane2;
        run(1, lat);
        check("par3_lat", 64'(lat), 64'd38);
        for (int r = 0; r < R; r++) check($sformatf("par3_y%0d", r), 64'(y_word(1, r)), 64'(int_to_fp16(4*r + 6)));
        check("par3_issue_count", 64'(vld_all1 - a1), 64'd48);
        check("par3_lane2_count", 64'(vld_lane2 - l2), 64'd15);

        // N=1: straight copy, including specials and a denormal, with no adds.
        for (int r = 0; r < R; r++) begin
            v = 16'h1234 + 16'(r) * 16'h0F1D;
            if (r == 5) v = 16'h7E00;
            if (r == 6) v = 16'hFC00;
            if (r == 7) v = 16'h0001;
            set_hc(2, r, 0, v);
        end
        a2 = vld_all2;
        run(2, lat);
        check("n1_lat", 64'(lat), 64'd2);
        for (int r = 0; r < R; r++) begin
            v = 16'h1234 + 16'(r) * 16'h0F1D;
            if (r == 5) v = 16'h7E00;
            if (r == 6) v = 16'hFC00;
            if (r == 7) v = 16'h0001;
            check($sformatf("n1_y%0d", r), 64'(y_word(2, r)), 64'(v));
        end
        check("n1_no_adds", 64'(vld_all2 - a2), 64'd0);

        // Reset in the middle of a run, then a clean restart.
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++) set_hc(0, r, n, FP16_ONE);
        @(negedge clk); bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus0.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_y", 64'(|bus0.y_flat), 64'd0);
        check("midrst_done", 64'(bus0.done), 64'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++) set_hc(0, r, n, int_to_fp16(r + n));
        run(0, lat);
        check("restart_lat", 64'(lat), 64'd23);
        for (int r = 0; r < R; r++) check($sformatf("restart_y%0d", r), 64'(y_word(0, r)), 64'(int_to_fp16(4*r + 6)));

        // Busy starts ignored; a start in the done cycle launches a second run.
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++) set_hc(0, r, n, FP16_ONE);
        @(negedge clk); bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus0.start = 1'b0;
        d1 = -1; d2 = -1; nd = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus0.done) begin
                nd++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            bus0.start = (c == 5) || (c == 12) || (bus0.done && (c == d1));
        end
        bus0.start = 1'b0;
        check("busy_first_done", 64'(d1), 64'd23);
        check("busy_second_done", 64'(d2), 64'd47);
        check("busy_done_count", 64'(nd), 64'd2);
        for (int r = 0; r < R; r += 5) check($sformatf("busy_y%0d", r), 64'(y_word(0, r)), 64'h4400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
